keypad_scan_decoder: RTL and testbench
======================================

KEYPAD_SCAN_DECODER -- requirements
Module: keypad_scan_decoder

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles per column step; legal range 4..65535.
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 50000, meaning consecutive stable cycles needed to accept a press or a release; legal range 1..2^20-1.
REQ-003 ACLK  in  1  single clock; all state on rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 col_n  out  4  column drive, active-low, exactly one bit low at any time.
REQ-006 row_n  in  4  row sense, active-low, asynchronous to ACLK, externally pulled up.
REQ-007 key_code  out  4  binary key index = row*4 + col of the last accepted key.
REQ-008 key_valid  out  1  new key pending; held until acknowledged.
REQ-009 key_ack  in  1  consumer (AXI slave register read) acknowledge, one-cycle pulse.
REQ-010 key_held  out  1  high while an accepted key is still physically pressed.
REQ-011 overrun  out  1  sticky flag: a key was accepted while key_valid was already high.

Function
REQ-012 row_n SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rows_s.
REQ-013 A step counter SHALL count 0..SCAN_DIV-1; the cycle with count SCAN_DIV-1 is the "tick".
REQ-014 The FSM SHALL have the states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-015 SCAN: col_n SHALL drive column c low; at each tick, if rows_s has exactly one bit low, the block SHALL latch row r and column c and go to DEBOUNCE; otherwise it SHALL advance c = (c+1) mod 4.
REQ-016 SCAN with zero or two or more rows low SHALL be ignored; it SHALL NOT cause ghost-key acceptance.
REQ-017 DEBOUNCE: column c SHALL stay driven and a 20-bit counter SHALL count cycles in which rows_s equals the latched pattern.
REQ-018 DEBOUNCE mismatch in any cycle SHALL clear the counter, return to SCAN and advance c.
REQ-019 DEBOUNCE reaching DEBOUNCE_CNT SHALL go to PRESSED.
REQ-020 On the PRESSED entry cycle the block SHALL load key_code = {r[1:0], c[1:0]}, set key_valid and set key_held.
REQ-021 If key_valid was already high without key_ack in that same cycle, the block SHALL set overrun and overwrite key_code.
REQ-022 PRESSED SHALL last one cycle, then go to RELEASE.
REQ-023 RELEASE: column c SHALL stay driven and the counter SHALL count cycles with rows_s == 4'b1111.
REQ-024 In RELEASE, any row low SHALL clear the counter.
REQ-025 RELEASE reaching DEBOUNCE_CNT SHALL clear key_held, go to SCAN with c = 0 and restart the step counter.
REQ-026 key_valid SHALL clear on the cycle after key_ack is sampled high.
REQ-027 If key_ack and a new acceptance occur in the same cycle, key_valid SHALL remain 1 with the new code and overrun SHALL NOT be set.
REQ-028 overrun SHALL clear only on key_ack, unless it is set in the same cycle.
REQ-029 key_ack while key_valid = 0 SHALL have no effect.
REQ-030 Minimum latency from a stable press on column c to key_valid SHALL be (ticks to reach c) + 2 sync cycles + DEBOUNCE_CNT + 1 cycles.

Reset
REQ-031 While ARESETN = 0, the block SHALL set state = SCAN, c = 0, col_n = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, overrun = 0, and clear all counters and synchronizer flops to 1.
REQ-032 Reset asserted mid-debounce or mid-press SHALL discard the pending key with no output pulse.
REQ-033 After release, scanning SHALL resume from column 0.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-034 Idle rows 4'b1111 for 64 cycles -> col_n cycles 1110, 1101, 1011, 0111 every 4 cycles, key_valid stays 0.
REQ-035 Hold row1/col2 (row_n = 1101 while col_n = 1011) -> key_code = 4'h6, key_valid = 1, key_held = 1. Release -> key_held = 0 after 8 stable cycles; key_ack -> key_valid = 0 on the next cycle.
REQ-036 Bounce row0 low for 3 cycles, then high, on col0 -> no acceptance, scanning continues at col1.
REQ-037 Two keys pressed, then a third with no ack -> key_code = the third key, overrun = 1; key_ack clears both flags.
REQ-038 Two rows low simultaneously on one column -> ignored, key_valid = 0.
REQ-039 ARESETN pulsed low during DEBOUNCE -> all outputs return to reset values immediately; the next press is accepted normally.

Source files
------------

// File: rtl/keypad_scan_decoder.sv
`timescale 1ns/1ps
// 4x4 matrix keypad scanner. It drives one active-low column at a time,
// debounces single-key presses and releases, and presents the key index with
// a valid/ack handshake and a sticky overrun flag.
module keypad_scan_decoder #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [15:0] STEP_LAST = 16'(SCAN_DIV - 1);
    localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CNT - 1);

    state_t      state_q, state_d;
    logic [3:0]  rows_m_q, rows_s_q;
    logic [3:0]  rows_s;
    logic [1:0]  col_q, col_d;
    logic [15:0] step_q, step_d;
    logic [19:0] db_q, db_d;
    logic [3:0]  pat_q, pat_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_held_q, key_held_d;
    logic        overrun_q, overrun_d;
    logic        accept;
    logic        ack_eff;

    // True when exactly one row line is pulled low.
    function automatic logic one_low(input logic [3:0] r);
        logic [3:0] a;
        a = ~r;
        return (a != 4'b0000) && ((a & (a - 4'd1)) == 4'b0000);
    endfunction

    // Binary index of the single low row in a latched pattern.
    function automatic logic [1:0] row_index(input logic [3:0] p);
        logic [1:0] idx;
        case (p)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    assign rows_s    = rows_s_q;
    assign col_n     = ~(4'b0001 << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

    // Two-flop synchronizer for the asynchronous row inputs (idle level is 1).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rows_m_q <= 4'hF;
            rows_s_q <= 4'hF;
        end else begin
            rows_m_q <= row_n;
            rows_s_q <= rows_m_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            step_q      <= 16'd0;
            db_q        <= 20'd0;
            pat_q       <= 4'hF;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            step_q      <= step_d;
            db_q        <= db_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: scan/debounce sequencing plus the valid/ack/overrun handshake.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        step_d      = step_q;
        db_d        = db_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_held_d  = key_held_q;
        overrun_d   = overrun_q;
        accept      = 1'b0;
        ack_eff     = key_ack && key_valid_q;

        case (state_q)
            SCAN: begin
                if (step_q == STEP_LAST) begin
                    step_d = 16'd0;
                    // Zero or several low rows are ambiguous (ghosting) and are skipped.
                    if (one_low(rows_s)) begin
                        pat_d   = rows_s;
                        db_d    = 20'd0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    step_d = step_q + 16'd1;
                end
            end
            DEBOUNCE: begin
                if (rows_s == pat_q) begin
                    if (db_q == DB_LAST) begin
                        db_d    = 20'd0;
                        state_d = PRESSED;
                    end else begin
                        db_d = db_q + 20'd1;
                    end
                end else begin
                    db_d    = 20'd0;
                    step_d  = 16'd0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end
            end
            PRESSED: begin
                accept  = 1'b1;
                db_d    = 20'd0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (rows_s == 4'hF) begin
                    if (db_q == DB_LAST) begin
                        db_d       = 20'd0;
                        key_held_d = 1'b0;
                        col_d      = 2'd0;
                        step_d     = 16'd0;
                        state_d    = SCAN;
                    end else begin
                        db_d = db_q + 20'd1;
                    end
                end else begin
                    db_d = 20'd0;
                end
            end
            default: state_d = SCAN;
        endcase

        // An ack arriving with a new key keeps valid high and suppresses overrun.
        if (accept) begin
            key_code_d  = {row_index(pat_q), col_q};
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
        end else if (ack_eff) begin
            key_valid_d = 1'b0;
        end

        if (accept && key_valid_q && !key_ack) begin
            overrun_d = 1'b1;
        end else if (ack_eff) begin
            overrun_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
`timescale 1ns/1ps
// Randomized bench for keypad_scan_decoder with a physical keypad model and a
// transaction-level reference of the expected key/valid/overrun/held outputs.
module tb_keypad_scan_decoder;

    localparam int SD = 4;
    localparam int DB = 8;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack = 1'b0;
    logic       key_held;
    logic       overrun;

    logic [15:0] pressed = 16'h0000;

    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_held  = 1'b0;
    logic [3:0] m_code  = 4'h0;

    int n_checks = 0;
    int n_errors = 0;

    keypad_scan_decoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 ACLK = ~ACLK;

    // Keypad matrix: a pressed switch shorts its row to its column when that column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Column driven while freely scanning, k cycles after scanning restarts at column 0.
    function automatic logic [3:0] idle_col(input int k);
        case ((k / SD) % 4)
            0: return 4'hE;
            1: return 4'hD;
            2: return 4'hB;
            default: return 4'h7;
        endcase
    endfunction

    // Cycles from a press (made when scanning restarts at column 0) to key_valid.
    function automatic int lat(input int c);
        return SD * (c + 1) + DB + 1;
    endfunction

    task automatic check_model(input string tag);
        check_val({tag, "_valid"}, 32'(key_valid), 32'(m_valid));
        check_val({tag, "_ovr"},   32'(overrun),   32'(m_ovr));
        check_val({tag, "_held"},  32'(key_held),  32'(m_held));
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETN = 1'b0;
        pressed = 16'h0000;
        key_ack = 1'b0;
        #1;
        check_val("rst_col",   32'(col_n),     32'(4'hE));
        check_val("rst_code",  32'(key_code),  32'(0));
        check_val("rst_valid", 32'(key_valid), 32'(0));
        check_val("rst_held",  32'(key_held),  32'(0));
        check_val("rst_ovr",   32'(overrun),   32'(0));
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_held  = 1'b0;
        m_code  = 4'h0;
    endtask

    // Press key (r,c) at a column-0 scan restart; ack_at selects the cycle (1..L) whose edge samples key_ack, 0 for none.
    task automatic press_and_wait(input int r, input int c, input int ack_at);
        int   L;
        logic acked;
        L = lat(c);
        pressed = 16'h0000;
        pressed[r*4+c] = 1'b1;
        for (int n = 1; n <= L; n++) begin
            key_ack = (n == ack_at);
            @(posedge ACLK);
            acked = key_ack;
            @(negedge ACLK);
            key_ack = 1'b0;
            if (n == L) begin
                if (acked) m_ovr = 1'b0;
                else       m_ovr = m_ovr | m_valid;
                m_valid = 1'b1;
                m_held  = 1'b1;
                m_code  = 4'(r * 4 + c);
            end else if (acked && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            check_model("press");
        end
        check_val("press_code", 32'(key_code), 32'(m_code));
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        key_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check_val("ack_valid", 32'(key_valid), 32'(m_valid));
        check_val("ack_ovr",   32'(overrun),   32'(m_ovr));
    endtask

    // Keep the key down for hold more cycles (optionally acking), then release and wait out the debounce.
    task automatic release_key(input int hold, input bit do_ack);
        if (do_ack) ack_pulse();
        repeat (hold) begin
            @(posedge ACLK);
            @(negedge ACLK);
            check_val("hold_held", 32'(key_held), 32'(1));
        end
        pressed = 16'h0000;
        for (int n = 1; n <= DB + 2; n++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            if (n == DB + 2) m_held = 1'b0;
            check_model("release");
        end
        check_val("release_code", 32'(key_code), 32'(m_code));
        check_val("release_col",  32'(col_n),    32'(4'hE));
    endtask

    initial begin
        int r, c, mode, at;

        // Idle scanning
        do_reset();
        check_val("idle_col0", 32'(col_n), 32'(4'hE));
        for (int k = 1; k <= 64; k++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            check_val("idle_col",   32'(col_n),     32'(idle_col(k)));
            check_val("idle_valid", 32'(key_valid), 32'(0));
        end

        // Row 1 / column 2
        do_reset();
        press_and_wait(1, 2, 0);
        check_val("key_r1c2", 32'(key_code), 32'(4'h6));
        release_key(2, 1'b0);
        check_val("r1c2_valid_kept", 32'(key_valid), 32'(1));
        ack_pulse();

        // Short bounce on row 0 / column 0
        do_reset();
        pressed[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            if (k == 3) pressed = 16'h0000;
            if (k == 4 || k == 5) check_val("bounce_hold_col", 32'(col_n), 32'(4'hE));
            if (k == 6 || k == 9) check_val("bounce_next_col", 32'(col_n), 32'(4'hD));
            if (k == 10)          check_val("bounce_col2",     32'(col_n), 32'(4'hB));
            check_val("bounce_valid", 32'(key_valid), 32'(0));
            check_val("bounce_held",  32'(key_held),  32'(0));
        end

        // Two rows low on one column
        do_reset();
        pressed[0*4+2] = 1'b1;
        pressed[3*4+2] = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            check_val("ghost_col",   32'(col_n),     32'(idle_col(k)));
            check_val("ghost_valid", 32'(key_valid), 32'(0));
            check_val("ghost_held",  32'(key_held),  32'(0));
        end

        // Reset in the middle of a debounce, then a normal press
        do_reset();
        pressed[2*4+1] = 1'b1;
        repeat (12) begin
            @(posedge ACLK);
            @(negedge ACLK);
        end
        check_val("debounce_col", 32'(col_n), 32'(4'hD));
        do_reset();
        press_and_wait(3, 3, 0);
        release_key(0, 1'b1);

        // Overrun build-up and clearing, then ack coinciding with acceptance
        do_reset();
        press_and_wait(0, 1, 0);
        release_key(0, 1'b0);
        press_and_wait(2, 3, 0);
        release_key(1, 1'b0);
        press_and_wait(3, 0, 0);
        check_val("ovr_code", 32'(key_code), 32'(4'hC));
        check_val("ovr_flag", 32'(overrun),  32'(1));
        release_key(0, 1'b1);
        press_and_wait(1, 1, 0);
        release_key(0, 1'b0);
        press_and_wait(2, 2, lat(2));
        check_val("coinc_valid", 32'(key_valid), 32'(1));
        check_val("coinc_ovr",   32'(overrun),   32'(0));
        check_val("coinc_code",  32'(key_code),  32'(4'hA));
        release_key(0, 1'b0);

        // Random key sequences with random acknowledge timing
        for (int t = 0; t < 16; t++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 2));
            if (mode == 0)      at = 0;
            else if (mode == 1) at = int'($urandom_range(1, lat(c) - 1));
            else                at = lat(c);
            press_and_wait(r, c, at);
            release_key(int'($urandom_range(0, 4)), ($urandom_range(0, 2) == 0));
        end

        // Reset while a key is held and pending
        press_and_wait(0, 3, 0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
